// File: rtl/gcd_ctrl_if.sv
// rtl/gcd_ctrl_if.sv - start/done handshake, datapath flags and datapath controls of the GCD controller
interface gcd_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             eqflg;
    logic             ltflg;
    logic             xmsel;
    logic             ymsel;
    logic             xld;
    logic             yld;
    logic             gld;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        output start, eqflg, ltflg,
        input  xmsel, ymsel, xld, yld, gld, busy, done, err, iter_cnt
    );

    modport slave (
        input  start, eqflg, ltflg,
        output xmsel, ymsel, xld, yld, gld, busy, done, err, iter_cnt
    );
endinterface

// File: rtl/gcd_ctrl.sv
// rtl/gcd_ctrl.sv - control FSM sequencing the subtractive GCD datapath, with iteration watchdog
// Define GCD_ITER_CNT_EN to expose the iteration counter on iter_cnt (tied to 0 otherwise).
module gcd_ctrl #(
    parameter int MAX_ITER = 15,
    parameter int CNT_W    = 4
) (
    input  logic      clk,
    input  logic      clr,
    gcd_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMP,
        S_SUBX,
        S_SUBY,
        S_STORE,
        S_DONE,
        S_ERR
    } state_t;

    typedef struct packed {
        logic xmsel;
        logic ymsel;
        logic xld;
        logic yld;
        logic gld;
        logic busy;
        logic done;
        logic err;
    } ctrl_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_LOAD:  begin c.xld = 1'b1; c.yld = 1'b1; c.busy = 1'b1; end
            S_CMP:   c.busy = 1'b1;
            S_SUBX:  begin c.xmsel = 1'b1; c.xld = 1'b1; c.busy = 1'b1; end
            S_SUBY:  begin c.ymsel = 1'b1; c.yld = 1'b1; c.busy = 1'b1; end
            S_STORE: begin c.gld = 1'b1; c.busy = 1'b1; end
            S_DONE:  c.done = 1'b1;
            S_ERR:   c.err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD:  state_d = S_CMP;
            S_CMP: begin
                if (bus.eqflg)           state_d = S_STORE;
                else if (cnt_q == MAX_CNT) state_d = S_ERR;
                else if (bus.ltflg)      state_d = S_SUBY;
                else                     state_d = S_SUBX;
            end
            S_SUBX, S_SUBY: begin
                state_d = S_CMP;
                if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
            end
            S_STORE: state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_LOAD : S_IDLE;
            S_ERR:   if (bus.start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
        // Counter restarts on entry to LOAD so the last count stays visible while idle.
        if (state_d == S_LOAD) cnt_d = '0;
        // Outputs are decoded from the next state so the registered copy lines up with the state.
        ctrl_d = decode(state_d);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.xmsel = ctrl_q.xmsel;
    assign bus.ymsel = ctrl_q.ymsel;
    assign bus.xld   = ctrl_q.xld;
    assign bus.yld   = ctrl_q.yld;
    assign bus.gld   = ctrl_q.gld;
    assign bus.busy  = ctrl_q.busy;
    assign bus.done  = ctrl_q.done;
    assign bus.err   = ctrl_q.err;

`ifdef GCD_ITER_CNT_EN
    assign bus.iter_cnt = cnt_q;
`else
    assign bus.iter_cnt = '0;
`endif
endmodule

// File: tb/tb_gcd_ctrl.sv
// tb/tb_gcd_ctrl.sv - self-checking bench for gcd_ctrl with a behavioural GCD datapath and reference model
module tb_gcd_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    gcd_ctrl_if #(.CNT_W(CNT_W)) bus ();
    gcd_ctrl #(.MAX_ITER(15), .CNT_W(CNT_W)) dut (.clk(clk), .clr(clr), .bus(bus));

    logic [3:0] xin = '0, yin = '0;
    logic [3:0] x_r, y_r, g_r;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            x_r <= '0; y_r <= '0; g_r <= '0;
        end else begin
            if (bus.xld) x_r <= bus.xmsel ? x_r - y_r : xin;
            if (bus.yld) y_r <= bus.ymsel ? y_r - x_r : yin;
            if (bus.gld) g_r <= x_r;
        end
    end
    assign bus.eqflg = (x_r == y_r);
    assign bus.ltflg = (x_r < y_r);

    typedef struct {
        logic [3:0] xin;
        logic [3:0] yin;
        logic [3:0] gcd;
        int         n;
        bit         err;
        int         cyc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_now();
        return {bus.xmsel, bus.ymsel, bus.xld, bus.yld, bus.gld, bus.busy, bus.done, bus.err};
    endfunction

    function automatic int exp_cnt(input int n);
`ifdef GCD_ITER_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Plain Euclid-by-subtraction with a 15-step budget.
    function automatic void ref_gcd(input int a, input int b, output int g, output int n, output bit e);
        n = 0;
        e = 1'b0;
        while (a != b && !e) begin
            if (n == 15) e = 1'b1;
            else begin
                if (a < b) b = b - a;
                else       a = a - b;
                n++;
            end
        end
        g = a;
    endfunction

    // Returns at the negedge inside cycle 1 (LOAD).
    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        xin = a; yin = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_end(output int cyc, output bit saw_done, output bit saw_err);
        cyc = 1; saw_done = 1'b0; saw_err = 1'b0;
        while (!saw_done && !saw_err && cyc < 80) begin
            @(negedge clk);
            cyc++;
            saw_done = bus.done;
            saw_err  = bus.err;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int cyc; bit d, e;
        start_op(v.xin, v.yin);
        wait_end(cyc, d, e);
        chk({name, "_finished"}, 32'(d | e), 1);
        chk({name, "_cycle"}, cyc, v.cyc);
        chk({name, "_err"}, 32'(e), 32'(v.err));
        chk({name, "_iter"}, bus.iter_cnt, exp_cnt(v.n));
        if (!v.err) chk({name, "_gcd"}, g_r, v.gcd);
        else begin
            repeat (3) @(negedge clk);
            chk({name, "_err_held"}, {bus.err, bus.done, bus.busy}, 3'b100);
        end
    endtask

    vec_t       vecs[6];
    logic [7:0] seq[9];

    initial begin
        int cyc; bit d, e;
        vec_t rv;
        vecs[0] = '{xin: 12, yin: 8,  gcd: 4, n: 2,  err: 0, cyc: 8};
        vecs[1] = '{xin: 15, yin: 1,  gcd: 1, n: 14, err: 0, cyc: 32};
        vecs[2] = '{xin: 0,  yin: 5,  gcd: 0, n: 15, err: 1, cyc: 33};
        vecs[3] = '{xin: 6,  yin: 9,  gcd: 3, n: 2,  err: 0, cyc: 8};
        vecs[4] = '{xin: 0,  yin: 0,  gcd: 0, n: 0,  err: 0, cyc: 4};
        vecs[5] = '{xin: 5,  yin: 0,  gcd: 0, n: 15, err: 1, cyc: 33};
        seq = '{8'b0011_0100, 8'b0000_0100, 8'b1010_0100, 8'b0000_0100, 8'b0101_0100,
                8'b0000_0100, 8'b0000_1100, 8'b0000_0010, 8'b0000_0000};
        bus.start = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_ctrl", ctrl_now(), 0);
        chk("reset_iter", bus.iter_cnt, 0);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ctrl", ctrl_now(), 0);

        // 12/8 control sequence, with a start pulse during SUBX that must be ignored.
        start_op(12, 8);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("seq_c%0d", i + 1), ctrl_now(), seq[i]);
            if (i == 2) bus.start = 1'b1;
            if (i == 7) chk("seq_iter", bus.iter_cnt, exp_cnt(2));
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("seq_gcd", g_r, 4);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Equal operands, then back-to-back start while in DONE.
        start_op(7, 7);
        wait_end(cyc, d, e);
        chk("eq_cycle", cyc, 4);
        chk("eq_done", 32'(d), 1);
        chk("eq_gcd", g_r, 7);
        xin = 6; yin = 9; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_load", ctrl_now(), 8'b0011_0100);
        wait_end(cyc, d, e);
        chk("b2b_cycle", cyc, 8);
        chk("b2b_gcd", g_r, 3);

        // Asynchronous reset in the middle of an operation.
        start_op(15, 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 clr = 1'b0;
        #1;
        chk("midclr_ctrl", ctrl_now(), 0);
        chk("midclr_iter", bus.iter_cnt, 0);
        chk("midclr_x", x_r, 0);
        @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("postclr_ctrl", ctrl_now(), 0);

        for (int k = 0; k < 20; k++) begin
            int g, n; bit er;
            rv.xin = 4'($urandom_range(0, 15));
            rv.yin = 4'($urandom_range(0, 15));
            ref_gcd(int'(rv.xin), int'(rv.yin), g, n, er);
            rv.gcd = 4'(g); rv.n = n; rv.err = er;
            rv.cyc = er ? 33 : 2 + 2 * n + 2;
            run_vec($sformatf("rnd%0d_%0d_%0d", k, rv.xin, rv.yin), rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcd_ctrl.md
Name: gcd_ctrl

Overview:
Control FSM that sequences the 4-bit subtractive GCD datapath. It loads operands, iterates compare/subtract steps until the operands are equal, then stores the result and reports completion with a start/done handshake. It also runs an iteration watchdog that turns non-terminating operand pairs (one operand zero) into a reported error. It sits beside the datapath in the GCD top level and drives all of the datapath's mux-select and load-enable controls.

Parameters:
MAX_ITER, 15, max subtractions allowed per operation before error; must fit in CNT_W bits.
CNT_W, 4, width of the iteration counter.

Ports:
clk  input  1  system clock, rising edge.
clr  input  1  asynchronous active-low reset; the top level inverts it before driving the datapath's clr.
start  input  1  begin operation; sampled only in IDLE, DONE or ERR.
eqflg  input  1  datapath flag, x==y.
ltflg  input  1  datapath flag, x<y.
xmsel  output  1  x mux select: 1 = x-y, 0 = xin.
ymsel  output  1  y mux select: 1 = y-x, 0 = yin.
xld  output  1  x register load enable.
yld  output  1  y register load enable.
gld  output  1  gcd register load enable.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse: gcd register holds a valid result.
err  output  1  watchdog tripped; held until next start or reset.
iter_cnt  output  CNT_W  subtraction count of the current or last operation (see Optional Feature).

Behaviour:
- States: IDLE, LOAD, CMP, SUBX, SUBY, STORE, DONE, ERR. Registered state. Outputs are Moore, decoded from state.
- Reset (clr=0, async): state=IDLE; counter=0. All outputs 0.
- IDLE: all controls 0. start=1 -> LOAD.
- LOAD: xmsel=0, ymsel=0, xld=1, yld=1, busy=1. Counter cleared to 0. Always -> CMP.
- CMP: busy=1, no loads. Priority of exits:
  - eqflg=1 -> STORE.
  - else counter==MAX_ITER -> ERR.
  - else ltflg=1 -> SUBY.
  - else -> SUBX.
- SUBX: xmsel=1, xld=1, busy=1; counter+1. -> CMP.
- SUBY: ymsel=1, yld=1, busy=1; counter+1. -> CMP.
- STORE: gld=1, busy=1. -> DONE.
- DONE: done=1, busy=0. start=1 -> LOAD (back-to-back operation); else -> IDLE.
- ERR: err=1, busy=0, no loads. start=1 -> LOAD, and err drops in LOAD. Otherwise ERR is held.
- start is ignored in LOAD, CMP, SUBX, SUBY and STORE. It is not queued.
- Latency: done is asserted in cycle 2+2N+2 after the start-sampling edge (N = number of subtractions). LOAD is cycle 1.
- Counter saturates at MAX_ITER and never wraps.
- Boundary cases:
  - (0,0): eq on first CMP -> result 0, N=0.
  - One operand zero, other nonzero: never equal -> ERR after MAX_ITER subtractions.
  - Equal nonzero operands: N=0.
- clr asserted mid-operation: immediate IDLE, all controls drop. The datapath registers are cleared by the same reset.

Optional Feature:
GCD_ITER_CNT_EN
- Defined: iter_cnt drives the internal counter. The value holds after DONE/ERR until the next LOAD.
- Undefined: iter_cnt is tied to 0; the counter is still present internally for the watchdog.

Test Plan:
- Reset: clr=0 during any state -> all outputs 0, state IDLE; release, no start -> outputs stay 0.
- xin=12, yin=8, start pulse -> sequence LOAD, CMP, SUBX, CMP, SUBY, CMP, STORE, DONE; done in cycle 8; gcd=4; iter_cnt=2 with GCD_ITER_CNT_EN.
- xin=15, yin=1 -> 14 SUBX steps, no err; done in cycle 32; gcd=1; iter_cnt=14.
- xin=0, yin=5 -> 15 SUBY steps, then ERR in cycle 33; err=1 held, done never asserts; a new start with 6,9 -> err clears in LOAD, gcd=3.
- xin=7, yin=7 -> CMP, STORE, DONE; done in cycle 4; gcd=7. start re-asserted in DONE -> LOAD on the next cycle. start pulsed while busy -> ignored.
- Build without GCD_ITER_CNT_EN -> iter_cnt=0 throughout the 12/8 case; gcd and done timing unchanged.
